// File: rtl/reflet_pwm_multi.sv
// reflet_pwm_multi: multi-channel PWM generator with a byte-wide register bus.
// Shadow registers (ctrl, prescale, period, duty[]) are written over the bus and
// copied into the active set only at period start (or continuously while stopped),
// so a period is never disturbed by a reprogramming write.
// Optional center-aligned (up/down) counting is enabled by the macro
// REFLET_PWM_MULTI_CENTER_EN; without it ctrl bit1 reads 0 and only edge mode exists.
module reflet_pwm_multi #(
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF1A,
  parameter int                        channels       = 4,
  parameter int                        width          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic                      write_en,
  output logic [channels-1:0]       out,
  output logic                      sync
);

  localparam logic [base_addr_size-1:0] num_regs = base_addr_size'(4 + 2 * channels);

  // bus decode
  logic [base_addr_size-1:0] offset;
  logic                      decoded;
  logic [4:0]                reg_sel;
  logic [3:0]                ch_sel;

  assign offset  = addr - base_addr;
  assign decoded = enable && (addr >= base_addr) && (offset < num_regs);
  assign reg_sel = offset[4:0];
  assign ch_sel  = reg_sel[4:1] - 4'd2;

  // shadow registers
  logic                run;
  logic                center;
  logic [7:0]          prescale;
  logic [width-1:0]    period;
  logic [width-1:0]    duty [channels];

  // active (per-period) state
  logic [7:0]          pre_cnt;
  logic [width-1:0]    count;
  logic                down;
  logic                running;
  logic [width-1:0]    act_period;
  logic [width-1:0]    act_duty [channels];

  // 16-bit zero-extended views used for byte reads and partial byte writes
  logic [15:0]         period_wide;
  logic [15:0]         duty_wide [16];
  logic [15:0]         period_wr;
  logic [15:0]         duty_wr;

  assign period_wide = 16'(period);

`ifndef REFLET_PWM_MULTI_CENTER_EN
  assign center = 1'b0;
`endif

  // widen duty registers into a fixed 16-entry table; unused entries read 0
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      duty_wide[i] = 16'h0000;
    end
    for (int i = 0; i < channels; i++) begin
      duty_wide[i] = 16'(duty[i]);
    end
  end

  // merge the written byte into the current value; odd offsets hold the high byte
  always_comb begin
    period_wr = period_wide;
    duty_wr   = duty_wide[ch_sel];
    if (reg_sel[0]) begin
      period_wr[15:8] = data_in;
      duty_wr[15:8]   = data_in;
    end else begin
      period_wr[7:0]  = data_in;
      duty_wr[7:0]    = data_in;
    end
  end

  // combinational read mux; undecoded accesses return 0
  always_comb begin
    data_out = 8'h00;
    if (decoded) begin
      case (reg_sel)
        5'd0:    data_out = {6'b000000, center, run};
        5'd1:    data_out = prescale;
        5'd2:    data_out = period_wide[7:0];
        5'd3:    data_out = period_wide[15:8];
        default: data_out = reg_sel[0] ? duty_wide[ch_sel][15:8] : duty_wide[ch_sel][7:0];
      endcase
    end else begin
      data_out = 8'h00;
    end
  end

  // shadow register writes; bits above width are dropped by the slice
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run      <= 1'b0;
`ifdef REFLET_PWM_MULTI_CENTER_EN
      center   <= 1'b0;
`endif
      prescale <= 8'h00;
      period   <= '0;
      for (int i = 0; i < channels; i++) begin
        duty[i] <= '0;
      end
    end else if (decoded && write_en) begin
      case (reg_sel)
        5'd0: begin
          run    <= data_in[0];
`ifdef REFLET_PWM_MULTI_CENTER_EN
          center <= data_in[1];
`endif
        end
        5'd1:    prescale <= data_in;
        5'd2:    period   <= period_wr[width-1:0];
        5'd3:    period   <= period_wr[width-1:0];
        default: begin
          for (int i = 0; i < channels; i++) begin
            if (ch_sel == 4'(i)) begin
              duty[i] <= duty_wr[width-1:0];
            end
          end
        end
      endcase
    end
  end

  // tick generation and next counter value; 'start' marks the tick where count becomes 0
  logic                tick;
  logic                start;
  logic [width-1:0]    count_nxt;
  logic                down_nxt;
  logic [channels-1:0] out_nxt;

  // next-state computation of the period counter
  always_comb begin
    tick      = run && (pre_cnt >= prescale);
    start     = 1'b0;
    count_nxt = count;
    down_nxt  = down;
    if (!running) begin
      // first tick after run rises: fresh period at count 0
      count_nxt = '0;
      down_nxt  = 1'b0;
      start     = 1'b1;
    end else if (center && down) begin
      count_nxt = count - width'(1'b1);
      if (count_nxt == '0) begin
        start    = 1'b1;
        down_nxt = 1'b0;
      end else begin
        down_nxt = 1'b1;
      end
    end else if (count >= act_period) begin
      if (center && (act_period != '0)) begin
        count_nxt = count - width'(1'b1);
        if (count_nxt == '0) begin
          start    = 1'b1;
          down_nxt = 1'b0;
        end else begin
          down_nxt = 1'b1;
        end
      end else begin
        count_nxt = '0;
        start     = 1'b1;
      end
    end else begin
      count_nxt = count + width'(1'b1);
    end
  end

  // output compare; the down slope uses <= so center mode stays high 2*duty ticks per period
  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < channels; i++) begin
      if (down_nxt) begin
        out_nxt[i] = (count_nxt <= (start ? duty[i] : act_duty[i]));
      end else begin
        out_nxt[i] = (count_nxt < (start ? duty[i] : act_duty[i]));
      end
    end
  end

  // prescaler, counter, active-set reload and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt    <= 8'h00;
      count      <= '0;
      down       <= 1'b0;
      running    <= 1'b0;
      out        <= '0;
      sync       <= 1'b0;
      act_period <= '0;
      for (int i = 0; i < channels; i++) begin
        act_duty[i] <= '0;
      end
    end else if (!run) begin
      pre_cnt    <= 8'h00;
      count      <= '0;
      down       <= 1'b0;
      running    <= 1'b0;
      out        <= '0;
      sync       <= 1'b0;
      act_period <= period;
      for (int i = 0; i < channels; i++) begin
        act_duty[i] <= duty[i];
      end
    end else if (tick) begin
      pre_cnt <= 8'h00;
      count   <= count_nxt;
      down    <= down_nxt;
      running <= 1'b1;
      out     <= out_nxt;
      sync    <= start;
      if (start) begin
        act_period <= period;
        for (int i = 0; i < channels; i++) begin
          act_duty[i] <= duty[i];
        end
      end
    end else begin
      pre_cnt <= pre_cnt + 8'd1;
      sync    <= 1'b0;
    end
  end

endmodule
